// File: rtl/axi_rdata_router.sv
// rtl/axi_rdata_router.sv - R-channel router: slaves to the master named by the IDS tag
// Locks one slave per burst and rotates round-robin so bursts never interleave.
module axi_rdata_router #(
  parameter int NS     = 7,
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NS*IDS_W-1:0]  RID_S,
  input  logic [NS*DATA_W-1:0] RDATA_S,
  input  logic [NS*2-1:0]      RRESP_S,
  input  logic [NS-1:0]        RLAST_S,
  input  logic [NS-1:0]        RVALID_S,
  output logic [NS-1:0]        RREADY_S,
  output logic [ID_W-1:0]      RID_M0,
  output logic [DATA_W-1:0]    RDATA_M0,
  output logic [1:0]           RRESP_M0,
  output logic                 RLAST_M0,
  output logic                 RVALID_M0,
  input  logic                 RREADY_M0,
  output logic [ID_W-1:0]      RID_M1,
  output logic [DATA_W-1:0]    RDATA_M1,
  output logic [1:0]           RRESP_M1,
  output logic                 RLAST_M1,
  output logic                 RVALID_M1,
  input  logic                 RREADY_M1,
  output logic [7:0]           drop_cnt
);

  localparam int GW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   grant, grant_nx;
  logic [GW-1:0]   rr_ptr, rr_ptr_nx;
  logic [GW-1:0]   arb_idx;
  logic            arb_found;
  int              arb_k;

  logic [1:0]        g_tag;
  logic [ID_W-1:0]   g_rid;
  logic [DATA_W-1:0] g_data;
  logic [1:0]        g_resp;
  logic              g_last;
  logic              g_valid;
  logic              g_ready;
  logic              g_bad;
  logic              busy;
  logic              hs;

  // Descending scan so the slave closest to rr_ptr wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_k     = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      arb_k = (int'(rr_ptr) + i) % NS;
      if (RVALID_S[arb_k]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(arb_k);
      end
    end
  end

  assign g_tag   = RID_S[grant*IDS_W + ID_W +: 2];
  assign g_rid   = RID_S[grant*IDS_W +: ID_W];
  assign g_data  = RDATA_S[grant*DATA_W +: DATA_W];
  assign g_resp  = RRESP_S[grant*2 +: 2];
  assign g_last  = RLAST_S[grant];
  assign g_valid = RVALID_S[grant];
  assign g_bad   = (g_tag[0] == g_tag[1]);
  assign busy    = (state == BUSY);
  assign hs      = busy & g_valid & g_ready;

  always_comb begin
    RREADY_S  = '0;
    g_ready   = 1'b0;
    RID_M0    = '0;
    RDATA_M0  = '0;
    RRESP_M0  = '0;
    RLAST_M0  = 1'b0;
    RVALID_M0 = 1'b0;
    RID_M1    = '0;
    RDATA_M1  = '0;
    RRESP_M1  = '0;
    RLAST_M1  = 1'b0;
    RVALID_M1 = 1'b0;
    if (busy) begin
      case (g_tag)
        2'b01: begin
          RID_M0    = g_rid;
          RDATA_M0  = g_data;
          RRESP_M0  = g_resp;
          RLAST_M0  = g_last;
          RVALID_M0 = g_valid;
          g_ready   = RREADY_M0;
        end
        2'b10: begin
          RID_M1    = g_rid;
          RDATA_M1  = g_data;
          RRESP_M1  = g_resp;
          RLAST_M1  = g_last;
          RVALID_M1 = g_valid;
          g_ready   = RREADY_M1;
        end
        // Unroutable tag: sink the beat so the slave is never stuck.
        default: g_ready = 1'b1;
      endcase
      RREADY_S[grant] = g_ready;
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    rr_ptr_nx = rr_ptr;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_nx = arb_idx;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (hs && g_last) begin
          state_nx  = IDLE;
          rr_ptr_nx = (grant == GW'(NS - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_ptr_nx;
      if (hs && g_bad && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_rdata_router.sv
// tb/tb_axi_rdata_router.sv - directed vector bench for axi_rdata_router
module tb_axi_rdata_router;

  localparam int NS = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*8-1:0] RID_S;
  logic [NS*32-1:0] RDATA_S;
  logic [NS*2-1:0] RRESP_S;
  logic [NS-1:0]   RLAST_S, RVALID_S, RREADY_S;
  logic [3:0]      RID_M0, RID_M1;
  logic [31:0]     RDATA_M0, RDATA_M1;
  logic [1:0]      RRESP_M0, RRESP_M1;
  logic            RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
  logic            RREADY_M0, RREADY_M1;
  logic [7:0]      drop_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_rdata_router dut (
    .clk(clk), .rst(rst),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0),
    .RLAST_M0(RLAST_M0), .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1),
    .RLAST_M1(RLAST_M1), .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        pre_rst;
    logic [6:0]  vm, lm;
    logic [7:0]  rid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        r0, r1;
    logic        ev0, ev1, el0, el1;
    logic [31:0] ed0, ed1;
    logic [6:0]  ers;
    logic [7:0]  edrop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pr, logic [6:0] vm, logic [6:0] lm, logic [7:0] rid,
                              logic [31:0] data, logic [1:0] resp, logic r0, logic r1,
                              logic ev0, logic ev1, logic el0, logic el1,
                              logic [31:0] ed0, logic [31:0] ed1, logic [6:0] ers,
                              logic [7:0] edrop);
    vec_t v;
    v.pre_rst = pr; v.vm = vm; v.lm = lm; v.rid = rid; v.data = data; v.resp = resp;
    v.r0 = r0; v.r1 = r1; v.ev0 = ev0; v.ev1 = ev1; v.el0 = el0; v.el1 = el1;
    v.ed0 = ed0; v.ed1 = ed1; v.ers = ers; v.edrop = edrop;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '0; RVALID_S = '0;
    RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drive(input vec_t v);
    RID_S   = {NS{v.rid}};
    RRESP_S = {NS{v.resp}};
    for (int k = 0; k < NS; k++)
      RDATA_S[k*32 +: 32] = {8'(k), v.data[23:0]};
    RVALID_S  = v.vm;
    RLAST_S   = v.lm;
    RREADY_M0 = v.r0;
    RREADY_M1 = v.r1;
  endtask

  // Called at posedge+1; samples at the following negedge, returns at posedge+1.
  task automatic apply(input vec_t v, input string tag);
    logic [3:0] erid0, erid1;
    logic [1:0] eresp0, eresp1;
    if (v.pre_rst) do_reset();
    drive(v);
    erid0  = v.ev0 ? v.rid[3:0] : 4'h0;
    erid1  = v.ev1 ? v.rid[3:0] : 4'h0;
    eresp0 = v.ev0 ? v.resp : 2'b00;
    eresp1 = v.ev1 ? v.resp : 2'b00;
    @(negedge clk);
    check({tag, " valid_last"}, 64'({RVALID_M0, RVALID_M1, RLAST_M0, RLAST_M1}),
          64'({v.ev0, v.ev1, v.el0, v.el1}));
    check({tag, " rready_s"}, 64'(RREADY_S), 64'(v.ers));
    check({tag, " m0"}, {26'd0, RID_M0, RRESP_M0, RDATA_M0}, {26'd0, erid0, eresp0, v.ed0});
    check({tag, " m1"}, {26'd0, RID_M1, RRESP_M1, RDATA_M1}, {26'd0, erid1, eresp1, v.ed1});
    check({tag, " drop_cnt"}, 64'(drop_cnt), 64'(v.edrop));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("reset valid_last", 64'({RVALID_M0, RVALID_M1, RLAST_M0, RLAST_M1}), 64'd0);
    check("reset rready_s", 64'(RREADY_S), 64'd0);
    check("reset data", {RDATA_M0, RDATA_M1}, 64'd0);
    check("reset drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single burst S1 -> M0, RID 8'h13
    vecs.push_back(mk(1, 7'h02, 7'h00, 8'h13, 32'hA0, 2'b00, 1, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 7'h02, 7'h00, 8'h13, 32'hA0, 2'b00, 1, 1, 1,0,0,0, 32'h010000A0, 0, 7'h02, 0));
    vecs.push_back(mk(0, 7'h02, 7'h00, 8'h13, 32'hA1, 2'b00, 1, 1, 1,0,0,0, 32'h010000A1, 0, 7'h02, 0));
    vecs.push_back(mk(0, 7'h02, 7'h00, 8'h13, 32'hA2, 2'b00, 1, 1, 1,0,0,0, 32'h010000A2, 0, 7'h02, 0));
    vecs.push_back(mk(0, 7'h02, 7'h02, 8'h13, 32'hA3, 2'b00, 1, 1, 1,0,1,0, 32'h010000A3, 0, 7'h02, 0));
    vecs.push_back(mk(0, 7'h00, 7'h00, 8'h13, 32'h00, 2'b00, 1, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    // Round-robin S0 and S5 -> M1 from rr_ptr 0
    vecs.push_back(mk(1, 7'h21, 7'h00, 8'h2A, 32'hB0, 2'b01, 0, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 7'h21, 7'h00, 8'h2A, 32'hB0, 2'b01, 0, 1, 0,1,0,0, 0, 32'h000000B0, 7'h01, 0));
    vecs.push_back(mk(0, 7'h21, 7'h01, 8'h2A, 32'hB1, 2'b01, 0, 1, 0,1,0,1, 0, 32'h000000B1, 7'h01, 0));
    vecs.push_back(mk(0, 7'h20, 7'h00, 8'h2A, 32'hB0, 2'b01, 0, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 7'h20, 7'h00, 8'h2A, 32'hB0, 2'b01, 0, 1, 0,1,0,0, 0, 32'h050000B0, 7'h20, 0));
    vecs.push_back(mk(0, 7'h20, 7'h20, 8'h2A, 32'hB1, 2'b01, 0, 1, 0,1,0,1, 0, 32'h050000B1, 7'h20, 0));
    vecs.push_back(mk(0, 7'h00, 7'h00, 8'h2A, 32'h00, 2'b01, 0, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    // Lock: S3 -> M1 with back-pressure while S0 waits; rr_ptr is 6 here
    vecs.push_back(mk(0, 7'h08, 7'h00, 8'h2C, 32'hC0, 2'b10, 0, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 7'h08, 7'h00, 8'h2C, 32'hC0, 2'b10, 0, 1, 0,1,0,0, 0, 32'h030000C0, 7'h08, 0));
    vecs.push_back(mk(0, 7'h09, 7'h00, 8'h2C, 32'hC1, 2'b10, 0, 0, 0,1,0,0, 0, 32'h030000C1, 7'h00, 0));
    vecs.push_back(mk(0, 7'h09, 7'h00, 8'h2C, 32'hC1, 2'b10, 0, 0, 0,1,0,0, 0, 32'h030000C1, 7'h00, 0));
    vecs.push_back(mk(0, 7'h09, 7'h00, 8'h2C, 32'hC1, 2'b10, 0, 1, 0,1,0,0, 0, 32'h030000C1, 7'h08, 0));
    vecs.push_back(mk(0, 7'h09, 7'h08, 8'h2C, 32'hC2, 2'b10, 0, 1, 0,1,0,1, 0, 32'h030000C2, 7'h08, 0));
    vecs.push_back(mk(0, 7'h01, 7'h00, 8'h2C, 32'hD0, 2'b10, 0, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 7'h01, 7'h01, 8'h2C, 32'hD0, 2'b10, 0, 1, 0,1,0,1, 0, 32'h000000D0, 7'h01, 0));
    vecs.push_back(mk(0, 7'h00, 7'h00, 8'h2C, 32'h00, 2'b10, 0, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    // Bad tag: default slave, RID 8'h35, 3 beats sunk
    vecs.push_back(mk(0, 7'h40, 7'h00, 8'h35, 32'hE0, 2'b00, 1, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 7'h40, 7'h00, 8'h35, 32'hE0, 2'b00, 1, 1, 0,0,0,0, 0, 0, 7'h40, 0));
    vecs.push_back(mk(0, 7'h40, 7'h00, 8'h35, 32'hE1, 2'b00, 1, 1, 0,0,0,0, 0, 0, 7'h40, 1));
    vecs.push_back(mk(0, 7'h40, 7'h40, 8'h35, 32'hE2, 2'b00, 1, 1, 0,0,0,0, 0, 0, 7'h40, 2));
    vecs.push_back(mk(0, 7'h00, 7'h00, 8'h35, 32'h00, 2'b00, 1, 1, 0,0,0,0, 0, 0, 7'h00, 3));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Mid-burst reset: S4 burst moves rr_ptr to 5, then S2 is cut off on beat 3
    apply(mk(1, 7'h10, 7'h10, 8'h17, 32'hF0, 2'b00, 1, 0, 0,0,0,0, 0, 0, 7'h00, 0), "rs0");
    apply(mk(0, 7'h10, 7'h10, 8'h17, 32'hF0, 2'b00, 1, 0, 1,0,1,0, 32'h040000F0, 0, 7'h10, 0), "rs1");
    apply(mk(0, 7'h04, 7'h00, 8'h17, 32'hF0, 2'b00, 1, 0, 0,0,0,0, 0, 0, 7'h00, 0), "rs2");
    apply(mk(0, 7'h04, 7'h00, 8'h17, 32'hF0, 2'b00, 1, 0, 1,0,0,0, 32'h020000F0, 0, 7'h04, 0), "rs3");
    apply(mk(0, 7'h04, 7'h00, 8'h17, 32'hF1, 2'b00, 1, 0, 1,0,0,0, 32'h020000F1, 0, 7'h04, 0), "rs4");
    drive(mk(0, 7'h24, 7'h00, 8'h17, 32'hF2, 2'b00, 1, 0, 0,0,0,0, 0, 0, 7'h00, 0));
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst valid", 64'({RVALID_M0, RVALID_M1, RLAST_M0, RLAST_M1}), 64'd0);
    check("midrst rready_s", 64'(RREADY_S), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    // S2 and S5 both waiting: S2 must win because rr_ptr restarted at 0
    apply(mk(0, 7'h24, 7'h00, 8'h17, 32'hF2, 2'b00, 1, 0, 0,0,0,0, 0, 0, 7'h00, 0), "rs5");
    apply(mk(0, 7'h24, 7'h00, 8'h17, 32'hF2, 2'b00, 1, 0, 1,0,0,0, 32'h020000F2, 0, 7'h04, 0), "rs6");
    apply(mk(0, 7'h24, 7'h04, 8'h17, 32'hF3, 2'b00, 1, 0, 1,0,1,0, 32'h020000F3, 0, 7'h04, 0), "rs7");
    apply(mk(0, 7'h00, 7'h00, 8'h17, 32'h00, 2'b00, 1, 0, 0,0,0,0, 0, 0, 7'h00, 0), "rs8");

    // Saturation: one long bad-tag burst from the default slave
    do_reset();
    drive(mk(0, 7'h40, 7'h00, 8'h35, 32'hE0, 2'b00, 1, 1, 0,0,0,0, 0, 0, 7'h00, 0));
    @(posedge clk);
    #1;
    for (int n = 0; n <= 300; n++) begin
      @(negedge clk);
      if (n == 254 || n == 255 || n == 300)
        check($sformatf("sat drop_cnt n=%0d", n), 64'(drop_cnt), (n > 255) ? 64'd255 : 64'(n));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
